// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, one-hot state encoding and address slicing helpers for the data cache.
package dcache_pkg;
  localparam int LINE_W = 512;
  localparam int OFF_W = 6;
  localparam int WSEL_W = 4;
  typedef enum logic [5:0] {
    ST_FREE   = 6'b000001,
    ST_LOOKUP = 6'b000010,
    ST_WBACK  = 6'b000100,
    ST_REFILL = 6'b001000,
    ST_UPDATE = 6'b010000,
    ST_RESP   = 6'b100000
  } state_t;
  localparam logic [5:0] STATE_FREE = ST_FREE;
  function automatic logic [WSEL_W-1:0] addr_wsel(input logic [31:2] a);
    return a[OFF_W-1:2];
  endfunction
  function automatic logic [31:OFF_W] addr_line(input logic [31:2] a);
    return a[31:OFF_W];
  endfunction
  function automatic logic [31:0] line_base(input logic [31:OFF_W] ln);
    return {ln, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: ME-stage request/response handshake plus the line-wide backing-memory port.
interface dcache_if;
  import dcache_pkg::*;
  logic req_valid, req_we, req_wide;
  logic [31:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic [5:0] state;
  logic resp_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic mem_req_valid, mem_req_we;
  logic [31:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic mem_req_ready, mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_rdata;
  modport master(
    output req_valid, req_we, req_wide, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  state, resp_valid, resp_rdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
  modport slave(
    input  req_valid, req_we, req_wide, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output state, resp_valid, resp_rdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage, one combinational read port and one write port with word merge.
module dcache_array import dcache_pkg::*; #(
  parameter int SETS = 16,
  localparam int IDX = $clog2(SETS),
  localparam int TAG_W = 32 - OFF_W - IDX
) (
  input  logic clk,
  input  logic rst,
  input  logic [IDX-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic rd_valid,
  output logic rd_dirty,
  output logic [LINE_W-1:0] rd_data,
  input  logic wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic wr_dirty,
  input  logic wr_wide,
  input  logic [WSEL_W-1:0] wr_wsel,
  input  logic [LINE_W-1:0] wr_data
);
  logic [TAG_W-1:0] tag [SETS];
  logic [LINE_W-1:0] data [SETS];
  logic [SETS-1:0] valid, dirty;
  assign rd_tag = tag[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_data = data[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx] <= wr_tag;
      if (wr_wide) data[wr_idx] <= wr_data;
      else data[wr_idx][{wr_wsel, 5'b0} +: 32] <= wr_data[31:0];
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate data cache controller for the ME stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int SETS = 16
) (
  input logic clk,
  input logic rst,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  dcache_if.slave bus
);
  localparam int IDX = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX;
  state_t st, nxt;
  logic r_we, r_wide, pend, refilled;
  logic [31:2] r_addr;
  logic [LINE_W-1:0] r_wdata, fill, rdata;
  logic [IDX-1:0] idx;
  logic [TAG_W-1:0] tag, v_tag, wr_tag;
  logic v_valid, v_dirty, hit, wstore, victim_dirty, mem_done;
  logic [LINE_W-1:0] v_data, wr_data;
  logic wr_en, wr_dirty, wr_wide;
  assign {tag, idx} = addr_line(r_addr);
  assign hit = v_valid && v_tag == tag;
  assign wstore = r_we && r_wide;
  assign victim_dirty = v_valid && v_dirty;
  // a response arriving together with the handshake completes the round trip
  assign mem_done = bus.mem_resp_valid && (!pend || bus.mem_req_ready);
  dcache_array #(.SETS(SETS)) u_array (
    .clk(clk), .rst(rst),
    .rd_idx(idx), .rd_tag(v_tag), .rd_valid(v_valid), .rd_dirty(v_dirty), .rd_data(v_data),
    .wr_en(wr_en), .wr_idx(idx), .wr_tag(wr_tag), .wr_dirty(wr_dirty), .wr_wide(wr_wide),
    .wr_wsel(addr_wsel(r_addr)), .wr_data(wr_data)
  );
  always_ff @(posedge clk) st <= rst ? ST_FREE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      ST_FREE:   nxt = bus.req_valid ? ST_LOOKUP : ST_FREE;
      ST_LOOKUP: nxt = hit ? ST_RESP : victim_dirty ? ST_WBACK : wstore ? ST_RESP : ST_REFILL;
      ST_WBACK:  nxt = !mem_done ? ST_WBACK : wstore ? ST_RESP : ST_REFILL;
      ST_REFILL: nxt = mem_done ? ST_UPDATE : ST_REFILL;
      ST_UPDATE: nxt = ST_LOOKUP;
      default:   nxt = ST_FREE;
    endcase
  end
  always_comb begin
    bus.state = st;
    bus.resp_valid = st == ST_RESP;
    wr_en = 1'b0;
    wr_dirty = 1'b1;
    wr_wide = r_wide;
    wr_tag = tag;
    wr_data = r_wdata;
    if (st == ST_LOOKUP && r_we && (hit || (wstore && !victim_dirty))) wr_en = 1'b1;
    else if (st == ST_WBACK && mem_done) begin
      wr_en = 1'b1;
      wr_dirty = wstore;
      wr_wide = 1'b1;
      wr_tag = wstore ? tag : v_tag;
      wr_data = wstore ? r_wdata : v_data;
    end else if (st == ST_UPDATE) begin
      wr_en = 1'b1;
      wr_dirty = 1'b0;
      wr_wide = 1'b1;
      wr_data = fill;
    end
  end
  assign bus.resp_rdata = rdata;
  assign bus.mem_req_valid = pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      refilled <= 1'b0;
      rdata <= '0;
      bus.mem_req_we <= 1'b0;
      bus.mem_req_addr <= '0;
      bus.mem_req_wdata <= '0;
    end else begin
      if (st == ST_FREE && bus.req_valid) begin
        r_we <= bus.req_we;
        r_wide <= bus.req_wide;
        r_addr <= bus.req_addr[31:2];
        r_wdata <= bus.req_wdata;
        refilled <= 1'b0;
      end
      if (pend && bus.mem_req_ready) pend <= 1'b0;
      if (st == ST_LOOKUP && nxt == ST_WBACK) begin
        pend <= 1'b1;
        bus.mem_req_we <= 1'b1;
        bus.mem_req_addr <= line_base({v_tag, idx});
        bus.mem_req_wdata <= v_data;
      end
      if (st != ST_REFILL && nxt == ST_REFILL) begin
        pend <= 1'b1;
        bus.mem_req_we <= 1'b0;
        bus.mem_req_addr <= line_base(addr_line(r_addr));
      end
      if (st == ST_REFILL && mem_done) fill <= bus.mem_resp_rdata;
      if (st == ST_UPDATE) refilled <= 1'b1;
      if (st == ST_LOOKUP && hit && !r_we)
        rdata <= r_wide ? v_data : {{(LINE_W-32){1'b0}}, v_data[{addr_wsel(r_addr), 5'b0} +: 32]};
    end
  end
`ifdef DCACHE_STATS_EN
  // the re-lookup after a refill is not a new access, so it is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (st == ST_LOOKUP && !refilled) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed-vector bench for dcache_ctrl with a small backing-memory responder.
module tb_dcache_ctrl;
  import dcache_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_if bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  dcache_ctrl #(.SETS(16)) dut (
    .clk(clk),
    .rst(rst),
`ifdef DCACHE_STATS_EN
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt),
`endif
    .bus(bus)
  );
  int nvec = 0;
  int nmis = 0;
  int stall = 0;
  bit mute = 1'b0;
  bit stale = 1'b0;
  logic [LINE_W-1:0] mem [bit [31:0]];
  logic [31:0] log_addr [$];
  logic log_we [$];
  logic [LINE_W-1:0] log_wdata [$];

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] seed);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed + 32'h01010101 * i;
    return l;
  endfunction

  // backing memory: answers with ready and response in the same cycle after `stall` waiting cycles
  initial begin
    int wcnt = 0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = stale;
      if (bus.mem_req_valid && !mute && !rst) begin
        if (wcnt < stall) wcnt++;
        else begin
          wcnt = 0;
          bus.mem_req_ready = 1'b1;
          bus.mem_resp_valid = 1'b1;
          log_addr.push_back(bus.mem_req_addr);
          log_we.push_back(bus.mem_req_we);
          log_wdata.push_back(bus.mem_req_wdata);
          if (bus.mem_req_we) mem[bus.mem_req_addr] = bus.mem_req_wdata;
          else bus.mem_resp_rdata = mem.exists(bus.mem_req_addr) ? mem[bus.mem_req_addr] : '0;
        end
      end
    end
  end

  task automatic xfer(input string tag, input logic we, input logic wide, input logic [31:0] addr,
                      input logic [LINE_W-1:0] wd, output logic [LINE_W-1:0] rd, output int lat, output int nreq);
    int n0;
    int b;
    n0 = log_addr.size();
    b = 0;
    lat = -1;
    rd = '0;
    @(negedge clk);
    while (bus.state !== STATE_FREE && b < 200) begin
      @(negedge clk);
      b++;
    end
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_wide = wide;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = n;
        rd = bus.resp_rdata;
        break;
      end
    end
    check({tag, "_resp_seen"}, lat > 0, 1'b1);
    nreq = log_addr.size() - n0;
  endtask

  task automatic watch_stall(input string tag, input logic [31:0] exp_addr, input logic [5:0] exp_st);
    int b;
    logic [LINE_W-1:0] wd0;
    b = 0;
    @(negedge clk);
    while (!bus.mem_req_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_req"}, bus.mem_req_valid, 1'b1);
    wd0 = bus.mem_req_wdata;
    repeat (5) begin
      check({tag, "_addr"}, bus.mem_req_addr, exp_addr);
      check({tag, "_state"}, bus.state, exp_st);
      check({tag, "_wdata"}, bus.mem_req_wdata, wd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [LINE_W-1:0] rd, e;
    int lat, nreq, n0, nresp, b;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_wide = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    mem[32'h40] = pat(32'hDEADBEEF);
    mem[32'h440] = pat(32'h0BADF00D);
    mem[32'h1040] = pat(32'h10000000);
    repeat (3) @(negedge clk);
    check("rst_state", bus.state, 6'b000001);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, '0);
    check("rst_mreq_valid", bus.mem_req_valid, 1'b0);
    check("rst_mreq_we", bus.mem_req_we, 1'b0);
    check("rst_mreq_addr", bus.mem_req_addr, 32'h0);
    check("rst_mreq_wdata", bus.mem_req_wdata, '0);
    rst = 1'b0;

    n0 = log_addr.size();
    xfer("cold_ld", 1'b0, 1'b0, 32'h40, '0, rd, lat, nreq);
    check("cold_ld_data", rd, 32'hDEADBEEF);
    check("cold_ld_nreq", nreq, 1);
    check("cold_ld_addr", log_addr[n0], 32'h40);
    check("cold_ld_we", log_we[n0], 1'b0);
`ifdef DCACHE_STATS_EN
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);
`endif

    xfer("hit_ld", 1'b0, 1'b0, 32'h44, '0, rd, lat, nreq);
    check("hit_ld_data", rd, 32'hDFAEBFF0);
    check("hit_ld_lat", lat, 2);
    check("hit_ld_nreq", nreq, 0);
`ifdef DCACHE_STATS_EN
    check("hit_hit_cnt", hit_cnt, 32'd1);
    check("hit_miss_cnt", miss_cnt, 32'd1);
`endif

    xfer("st48", 1'b1, 1'b0, 32'h48, 512'h12345678, rd, lat, nreq);
    check("st48_lat", lat, 2);
    check("st48_nreq", nreq, 0);
    n0 = log_addr.size();
    xfer("ld440", 1'b0, 1'b0, 32'h440, '0, rd, lat, nreq);
    check("ld440_data", rd, 32'h0BADF00D);
    check("ld440_nreq", nreq, 2);
    check("wb_addr", log_addr[n0], 32'h40);
    check("wb_we", log_we[n0], 1'b1);
    check("wb_word2", log_wdata[n0][95:64], 32'h12345678);
    check("wb_word0", log_wdata[n0][31:0], 32'hDEADBEEF);
    check("rf440_addr", log_addr[n0+1], 32'h440);
    check("rf440_we", log_we[n0+1], 1'b0);

    xfer("wst800", 1'b1, 1'b1, 32'h800, pat(32'h55AA0000), rd, lat, nreq);
    check("wst800_lat", lat, 2);
    check("wst800_nreq", nreq, 0);
    xfer("wld800", 1'b0, 1'b1, 32'h83C, '0, rd, lat, nreq);
    check("wld800_data", rd, pat(32'h55AA0000));
    check("wld800_lat", lat, 2);

    xfer("st804", 1'b1, 1'b0, 32'h806, 512'h600DCAFE, rd, lat, nreq);
    xfer("ld804", 1'b0, 1'b0, 32'h804, '0, rd, lat, nreq);
    check("ld804_data", rd, 32'h600DCAFE);
    e = pat(32'h55AA0000);
    e[63:32] = 32'h600DCAFE;
    xfer("wld800b", 1'b0, 1'b1, 32'h800, '0, rd, lat, nreq);
    check("wld800_merge", rd, e);

    stall = 5;
    fork
      xfer("stall_rf", 1'b0, 1'b0, 32'h1044, '0, rd, lat, nreq);
      watch_stall("stall_rf", 32'h1040, 6'b001000);
    join
    check("stall_rf_data", rd, 32'h11010101);
    stall = 0;
    xfer("st1040", 1'b1, 1'b0, 32'h1040, 512'hA5A5A5A5, rd, lat, nreq);
    check("st1040_nreq", nreq, 0);
    stall = 5;
    n0 = log_addr.size();
    fork
      xfer("stall_wb", 1'b0, 1'b0, 32'h40, '0, rd, lat, nreq);
      watch_stall("stall_wb", 32'h1040, 6'b000100);
    join
    stall = 0;
    check("stall_wb_data", rd, 32'hDEADBEEF);
    check("stall_wb_word0", log_wdata[n0][31:0], 32'hA5A5A5A5);
    check("stall_wb_word1", log_wdata[n0][63:32], 32'h11010101);

    mute = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_wide = 1'b0;
    bus.req_addr = 32'h2080;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    b = 0;
    @(negedge clk);
    while (bus.state !== 6'b001000 && b < 20) begin
      @(negedge clk);
      b++;
    end
    repeat (2) @(negedge clk);
    check("rfw_state", bus.state, 6'b001000);
    check("rfw_mreq_valid", bus.mem_req_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", bus.state, 6'b000001);
    check("mid_rst_mreq_valid", bus.mem_req_valid, 1'b0);
    rst = 1'b0;
    mute = 1'b0;
    stale = 1'b1;
    @(posedge clk);
    #3 stale = 1'b0;
    nresp = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    check("stale_resp", nresp, 0);
    check("stale_state", bus.state, 6'b000001);
    xfer("post_rst_ld", 1'b0, 1'b0, 32'h48, '0, rd, lat, nreq);
    check("post_rst_data", rd, 32'h12345678);
    check("post_rst_nreq", nreq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller serving the ME stage's memory requests: 32-bit word loads/stores and 512-bit line loads/stores for matrix operands. It is the responder end of the ME stage handshake. Its `state` output drives `Data_Cache_state`, and the ME stage treats `STATE_FREE` as "cache able to accept." On a miss it writes back the victim and refills the line through a line-wide request/response port to backing memory.

## Interface
- `SETS`, 16: number of lines; power of two, at least 2. IDX = log2(SETS).
- `LINE_W`, 512: line width in bits; fixed at 512.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: ME request present; accepted only in the cycle where `state == STATE_FREE`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_wide` in 1: 1 = 512-bit line access, 0 = 32-bit word access.
- `req_addr` in 32: byte address. Word accesses ignore [1:0]; wide accesses ignore [5:0].
- `req_wdata` in 512: store data; word stores use [31:0].
- `state` out 6: one-hot FSM state; drives `Data_Cache_state`.
- `resp_valid` out 1: single-cycle completion pulse.
- `resp_rdata` out 512: load data, valid while `resp_valid` is high. Word loads are zero-extended in [31:0].
- `mem_req_valid` out 1: backing memory request.
- `mem_req_we` out 1: 1 = writeback, 0 = refill.
- `mem_req_addr` out 32: line-aligned; [5:0] = 0.
- `mem_req_wdata` out 512: victim line.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: refill data or writeback acknowledge.
- `mem_resp_rdata` in 512: refill line.
- `hit_cnt`, `miss_cnt` out 32 each: present only with `DCACHE_STATS_EN`.

## Operation
- Address split:
  - word select = [5:2]
  - index = [5+IDX:6]
  - tag = [31:6+IDX]
- States, one-hot:
  - FREE = 000001
  - LOOKUP = 000010
  - WBACK = 000100
  - REFILL = 001000
  - UPDATE = 010000
  - RESP = 100000
- FREE:
  - On `req_valid`, latch `we`, `wide`, `addr`, `wdata`; go to LOOKUP.
  - Otherwise stay in FREE.
- LOOKUP, hit (valid and tag match):
  - Load: capture line (wide) or selected word (word) into `resp_rdata`.
  - Store: write the line or word and set dirty.
  - Go to RESP.
- LOOKUP, miss:
  - Victim valid and dirty: go to WBACK.
  - Otherwise, wide store: overwrite the line, set valid and dirty, set tag, go to RESP. No refill.
  - Otherwise: go to REFILL.
- WBACK:
  - Assert `mem_req_valid` with `mem_req_we` = 1, address {victim tag, index, 6'b0}, and the victim data.
  - Deassert `mem_req_valid` the cycle after the handshake.
  - Wait for `mem_resp_valid`, then clear dirty. Next state is RESP if the request is a wide store (line overwritten), otherwise REFILL.
- REFILL:
  - Request with `mem_req_we` = 0 and the line-aligned request address.
  - Deassert `mem_req_valid` the cycle after the handshake.
  - On `mem_resp_valid`, latch `mem_resp_rdata` and go to UPDATE.
- UPDATE: write the refilled line, valid = 1, dirty = 0, tag = request tag. Return to LOOKUP, which now hits.
- RESP: `resp_valid` = 1 for exactly one cycle, then go to FREE.
- `mem_resp_valid` outside WBACK and REFILL is ignored.

## Timing
- Reset values:
  - `state` = FREE.
  - `resp_valid` = 0, `resp_rdata` = 0.
  - `mem_req_valid` = 0, `mem_req_we` = 0, `mem_req_addr` = 0, `mem_req_wdata` = 0.
  - All valid and dirty bits = 0; counters = 0.
- Reset mid-operation: abandon the transaction in any state and return to FREE next cycle. Backing memory shares `rst`.
- Hit latency: request accepted at cycle t; LOOKUP at t+1; `resp_valid` at t+2. Next accept at t+3.
- Miss latency: 2 + writeback round trip (if dirty) + refill round trip + 1 (UPDATE) + 1 (re-LOOKUP).
- `mem_req_*` fields are stable while `mem_req_valid` = 1 and `mem_req_ready` = 0.
- `mem_req_ready` and `mem_resp_valid` in the same cycle: accepted. Proceed straight to the next step.
- Back-to-back requests to the same line: the second sees the first's store (write-first array).

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_cnt` increments on a first-pass LOOKUP hit.
  - `miss_cnt` increments on a first-pass LOOKUP miss.
  - The re-LOOKUP after UPDATE counts neither.
  - Both counters are 32-bit, wrap around, and are cleared by `rst`.
- Undefined: ports and counter logic absent; behaviour otherwise identical.

## Structure
- Shared package `dcache_pkg`:
  - one-hot state constants (FREE matches `STATE_FREE`)
  - `LINE_W`, offset width 6
  - word-select width 4
  - address field slicing helpers
- Sub-module `dcache_array`: tag, valid, dirty and data flops, with one read port and one write port.
  - Word-write merge into the line happens inside `dcache_array`.
  - Synchronous clear of valid and dirty on `rst`.

## Test plan
- Cold word load at 0x0000_0040: refill requested at 0x40; memory returns line with word0 = 0xDEADBEEF → `resp_rdata` = 0xDEADBEEF, `miss_cnt` = 1.
- Word load at 0x44 after that fill → `resp_valid` exactly 2 cycles after accept, no `mem_req_valid`, `hit_cnt` = 1.
- Word store 0x12345678 to 0x48, then load at 0x440 (same index, SETS = 16):
  - writeback at 0x40 carries 0x12345678 in bits [95:64]
  - then refill at 0x440
- Wide store to a clean miss line 0x800 → no memory traffic; the following wide load returns the identical 512 bits.
- `mem_req_ready` held low for 5 cycles → `mem_req_addr`/`mem_req_wdata` stable, `state` = REFILL or WBACK throughout.
- Assert `rst` during REFILL wait → `state` = FREE and `mem_req_valid` = 0 next cycle; a stale `mem_resp_valid` afterwards causes no `resp_valid`.
